// File: rtl/pong_ball_engine.sv
// pong_ball_engine
//
// Ball engine for the Pong datapath. It holds the ball position and direction and moves the
// ball once per tick. It resolves wall bounces, paddle hits and misses against both paddles,
// and runs the serve / play / point sequence with two saturating scores.
//
// Optional feature: define BALL_SPEEDUP_EN to latch the step at the start of each rally and
// add 1 px/tick (saturating at 31) on every paddle hit. When it is undefined, the step
// follows `speed` on every tick.
//
// Ports:
//   clk                    clock
//   reset                  synchronous, active-low
//   tick                   one-cycle move strobe (one per frame)
//   speed[4:0]             px per tick on each axis (0 behaves as 1)
//   paddle_l_y, paddle_r_y top edge of the left / right paddle
//   ball_x, ball_y         ball top-left corner
//   dir_x, dir_y           1 = right / down, 0 = left / up
//   hit_l, hit_r           one-cycle paddle-hit pulses
//   miss_l, miss_r         one-cycle miss pulses
//   score_l, score_r       saturating scores
//   state[1:0]             0 = serve, 1 = play, 2 = point
module pong_ball_engine #(
    parameter int unsigned COORD_W        = 11,
    parameter int unsigned FIELD_W        = 160,
    parameter int unsigned FIELD_H        = 120,
    parameter int unsigned BALL_SIZE      = 4,
    parameter int unsigned PADDLE_H       = 20,
    parameter int unsigned LEFT_PADDLE_X  = 8,
    parameter int unsigned RIGHT_PADDLE_X = 152,
    parameter int unsigned SERVE_TICKS    = 60
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic [4:0]         speed,
    input  logic [COORD_W-1:0] paddle_l_y,
    input  logic [COORD_W-1:0] paddle_r_y,
    output logic [COORD_W-1:0] ball_x,
    output logic [COORD_W-1:0] ball_y,
    output logic               dir_x,
    output logic               dir_y,
    output logic               hit_l,
    output logic               hit_r,
    output logic               miss_l,
    output logic               miss_r,
    output logic [3:0]         score_l,
    output logic [3:0]         score_r,
    output logic [1:0]         state
);

    // One extra bit so that position + step never wraps before it is compared.
    localparam int unsigned AW   = COORD_W + 1;
    localparam int unsigned CntW = $clog2(SERVE_TICKS + 1);

    localparam logic [1:0] StServe = 2'd0;
    localparam logic [1:0] StPlay  = 2'd1;
    localparam logic [1:0] StPoint = 2'd2;

    localparam logic [AW-1:0] CenterX   = AW'((FIELD_W - BALL_SIZE) / 2);
    localparam logic [AW-1:0] CenterY   = AW'((FIELD_H - BALL_SIZE) / 2);
    localparam logic [AW-1:0] XMax      = AW'(FIELD_W - BALL_SIZE);
    localparam logic [AW-1:0] YMax      = AW'(FIELD_H - BALL_SIZE);
    localparam logic [AW-1:0] BallSize  = AW'(BALL_SIZE);
    localparam logic [AW-1:0] PadH      = AW'(PADDLE_H);
    localparam logic [AW-1:0] LeftStop  = AW'(LEFT_PADDLE_X);
    localparam logic [AW-1:0] RightStop = AW'(RIGHT_PADDLE_X - BALL_SIZE);

    localparam logic [CntW-1:0] ServeLast = CntW'(SERVE_TICKS - 1);

    logic [1:0]         state_q, state_d;
    logic [COORD_W-1:0] ball_x_q, ball_x_d;
    logic [COORD_W-1:0] ball_y_q, ball_y_d;
    logic               dir_x_q, dir_x_d;
    logic               dir_y_q, dir_y_d;
    logic               serve_dir_y_q, serve_dir_y_d;
    logic               hit_l_q, hit_l_d;
    logic               hit_r_q, hit_r_d;
    logic               miss_l_q, miss_l_d;
    logic               miss_r_q, miss_r_d;
    logic [3:0]         score_l_q, score_l_d;
    logic [3:0]         score_r_q, score_r_d;
    logic [CntW-1:0]    serve_cnt_q, serve_cnt_d;

    logic [4:0]    speed_min1;
    logic [4:0]    step;
    logic [AW-1:0] step_w;
    logic [AW-1:0] bx, by, pl, pr;
    logic [AW-1:0] bx_next, by_next;
    logic          overlap_l, overlap_r;

`ifdef BALL_SPEEDUP_EN
    logic [4:0] step_q, step_d;
    assign step = step_q;
`else
    assign step = speed_min1;
`endif

    assign speed_min1 = (speed == 5'd0) ? 5'd1 : speed;
    assign step_w     = AW'(step);
    assign bx         = AW'(ball_x_q);
    assign by         = AW'(ball_y_q);
    assign pl         = AW'(paddle_l_y);
    assign pr         = AW'(paddle_r_y);

    // Paddle overlap uses the ball's pre-move y.
    assign overlap_l = (by + BallSize > pl) && (by < pl + PadH);
    assign overlap_r = (by + BallSize > pr) && (by < pr + PadH);

    always_comb begin
        state_d       = state_q;
        bx_next       = bx;
        by_next       = by;
        dir_x_d       = dir_x_q;
        dir_y_d       = dir_y_q;
        serve_dir_y_d = serve_dir_y_q;
        hit_l_d       = 1'b0;
        hit_r_d       = 1'b0;
        miss_l_d      = 1'b0;
        miss_r_d      = 1'b0;
        score_l_d     = score_l_q;
        score_r_d     = score_r_q;
        serve_cnt_d   = serve_cnt_q;
`ifdef BALL_SPEEDUP_EN
        step_d        = step_q;
`endif

        if (tick) begin
            case (state_q)
                StServe: begin
                    if (serve_cnt_q == ServeLast) begin
                        state_d     = StPlay;
                        serve_cnt_d = '0;
`ifdef BALL_SPEEDUP_EN
                        step_d      = speed_min1;
`endif
                    end else begin
                        serve_cnt_d = serve_cnt_q + CntW'(1);
                    end
                end

                StPlay: begin
                    // Y axis: bounce off top and bottom walls.
                    if (!dir_y_q) begin
                        if (by <= step_w) begin
                            by_next = '0;
                            dir_y_d = 1'b1;
                        end else begin
                            by_next = by - step_w;
                        end
                    end else if (by + step_w >= YMax) begin
                        by_next = YMax;
                        dir_y_d = 1'b0;
                    end else begin
                        by_next = by + step_w;
                    end

                    // X axis: paddle hit wins over a miss.
                    if (dir_x_q) begin
                        if ((bx + step_w >= RightStop) && (bx < RightStop) && overlap_r) begin
                            bx_next = RightStop;
                            dir_x_d = 1'b0;
                            hit_r_d = 1'b1;
`ifdef BALL_SPEEDUP_EN
                            step_d  = (step_q == 5'd31) ? step_q : step_q + 5'd1;
`endif
                        end else if (bx + step_w >= XMax) begin
                            bx_next  = XMax;
                            miss_r_d = 1'b1;
                            state_d  = StPoint;
                            if (score_l_q != 4'hf) begin
                                score_l_d = score_l_q + 4'd1;
                            end
                        end else begin
                            bx_next = bx + step_w;
                        end
                    end else begin
                        if ((bx <= LeftStop + step_w) && (bx > LeftStop) && overlap_l) begin
                            bx_next = LeftStop;
                            dir_x_d = 1'b1;
                            hit_l_d = 1'b1;
`ifdef BALL_SPEEDUP_EN
                            step_d  = (step_q == 5'd31) ? step_q : step_q + 5'd1;
`endif
                        end else if (bx <= step_w) begin
                            bx_next  = '0;
                            miss_l_d = 1'b1;
                            state_d  = StPoint;
                            if (score_r_q != 4'hf) begin
                                score_r_d = score_r_q + 4'd1;
                            end
                        end else begin
                            bx_next = bx - step_w;
                        end
                    end
                end

                StPoint: begin
                    // dir_x is left untouched: on a miss it already points at the side
                    // that conceded, which is where the next serve goes.
                    bx_next       = CenterX;
                    by_next       = CenterY;
                    serve_dir_y_d = ~serve_dir_y_q;
                    dir_y_d       = ~serve_dir_y_q;
                    state_d       = StServe;
                end

                default: begin
                    state_d = StServe;
                end
            endcase
        end

        ball_x_d = bx_next[COORD_W-1:0];
        ball_y_d = by_next[COORD_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= StServe;
            ball_x_q      <= CenterX[COORD_W-1:0];
            ball_y_q      <= CenterY[COORD_W-1:0];
            dir_x_q       <= 1'b1;
            dir_y_q       <= 1'b1;
            serve_dir_y_q <= 1'b1;
            hit_l_q       <= 1'b0;
            hit_r_q       <= 1'b0;
            miss_l_q      <= 1'b0;
            miss_r_q      <= 1'b0;
            score_l_q     <= 4'd0;
            score_r_q     <= 4'd0;
            serve_cnt_q   <= '0;
`ifdef BALL_SPEEDUP_EN
            step_q        <= speed_min1;
`endif
        end else begin
            state_q       <= state_d;
            ball_x_q      <= ball_x_d;
            ball_y_q      <= ball_y_d;
            dir_x_q       <= dir_x_d;
            dir_y_q       <= dir_y_d;
            serve_dir_y_q <= serve_dir_y_d;
            hit_l_q       <= hit_l_d;
            hit_r_q       <= hit_r_d;
            miss_l_q      <= miss_l_d;
            miss_r_q      <= miss_r_d;
            score_l_q     <= score_l_d;
            score_r_q     <= score_r_d;
            serve_cnt_q   <= serve_cnt_d;
`ifdef BALL_SPEEDUP_EN
            step_q        <= step_d;
`endif
        end
    end

    assign state   = state_q;
    assign ball_x  = ball_x_q;
    assign ball_y  = ball_y_q;
    assign dir_x   = dir_x_q;
    assign dir_y   = dir_y_q;
    assign hit_l   = hit_l_q;
    assign hit_r   = hit_r_q;
    assign miss_l  = miss_l_q;
    assign miss_r  = miss_r_q;
    assign score_l = score_l_q;
    assign score_r = score_r_q;

endmodule

// File: tb/tb_pong_ball_engine.sv
// tb_pong_ball_engine
//
// Bench for pong_ball_engine at default parameters. A game-level model (plain integers)
// advances alongside the DUT and every output is compared to it each cycle; directed rallies
// with hand-worked positions pin the model. Extra speed-up scenarios run when
// BALL_SPEEDUP_EN is defined.
module tb_pong_ball_engine;

    localparam int FW  = 160;
    localparam int FH  = 120;
    localparam int BS  = 4;
    localparam int PH  = 20;
    localparam int LPX = 8;
    localparam int RPX = 152;
    localparam int STK = 60;
    localparam int CX  = (FW - BS) / 2;
    localparam int CY  = (FH - BS) / 2;
`ifdef BALL_SPEEDUP_EN
    localparam bit SPEEDUP = 1'b1;
`else
    localparam bit SPEEDUP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        tick = 1'b0;
    logic [4:0]  speed = 5'd2;
    logic [10:0] paddle_l_y = 11'd100;
    logic [10:0] paddle_r_y = 11'd100;
    logic [10:0] ball_x, ball_y;
    logic        dir_x, dir_y, hit_l, hit_r, miss_l, miss_r;
    logic [3:0]  score_l, score_r;
    logic [1:0]  state;

    always #5 clk = ~clk;

    pong_ball_engine dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .speed      (speed),
        .paddle_l_y (paddle_l_y),
        .paddle_r_y (paddle_r_y),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .dir_x      (dir_x),
        .dir_y      (dir_y),
        .hit_l      (hit_l),
        .hit_r      (hit_r),
        .miss_l     (miss_l),
        .miss_r     (miss_r),
        .score_l    (score_l),
        .score_r    (score_r),
        .state      (state)
    );

    // Game model: st 0 serve, 1 play, 2 point.
    typedef struct {
        int st;
        int x;
        int y;
        int dx;
        int dy;
        int sl;
        int sr;
        int cnt;
        int step;
        int sdy;
        int lost_r;
        int hl;
        int hr;
        int ml;
        int mr;
    } mdl_t;

    mdl_t m;
    int   n_pass = 0;
    int   n_total = 0;
    bit   chk_en = 1'b0;
    bit   follow = 1'b0;

    function automatic mdl_t model_next(mdl_t c, logic rst, logic tk, int spd, int ply, int pry);
        mdl_t n;
        int   s;
        int   s_in;
        bit   ov_l;
        bit   ov_r;
        n    = c;
        s_in = (spd == 0) ? 1 : spd;
        if (!rst) begin
            n.st = 0; n.x = CX; n.y = CY; n.dx = 1; n.dy = 1; n.sl = 0; n.sr = 0;
            n.cnt = 0; n.step = s_in; n.sdy = 1; n.lost_r = 0;
            n.hl = 0; n.hr = 0; n.ml = 0; n.mr = 0;
            return n;
        end
        n.hl = 0; n.hr = 0; n.ml = 0; n.mr = 0;
        if (!tk) return n;
        if (c.st == 0) begin
            if (c.cnt == STK - 1) begin
                n.st = 1; n.cnt = 0; n.step = s_in;
            end else begin
                n.cnt = c.cnt + 1;
            end
        end else if (c.st == 1) begin
            s = SPEEDUP ? c.step : s_in;
            if (c.dy == 0) begin
                if (c.y <= s) begin n.y = 0; n.dy = 1; end
                else n.y = c.y - s;
            end else begin
                if (c.y + s >= FH - BS) begin n.y = FH - BS; n.dy = 0; end
                else n.y = c.y + s;
            end
            ov_l = (c.y + BS > ply) && (c.y < ply + PH);
            ov_r = (c.y + BS > pry) && (c.y < pry + PH);
            if (c.dx == 1) begin
                if (c.x + s >= RPX - BS && c.x < RPX - BS && ov_r) begin
                    n.x = RPX - BS; n.dx = 0; n.hr = 1;
                    if (SPEEDUP) n.step = (c.step < 31) ? c.step + 1 : 31;
                end else if (c.x + s >= FW - BS) begin
                    n.x = FW - BS; n.mr = 1; n.st = 2; n.lost_r = 1;
                    n.sl = (c.sl < 15) ? c.sl + 1 : 15;
                end else begin
                    n.x = c.x + s;
                end
            end else begin
                if (c.x <= LPX + s && c.x > LPX && ov_l) begin
                    n.x = LPX; n.dx = 1; n.hl = 1;
                    if (SPEEDUP) n.step = (c.step < 31) ? c.step + 1 : 31;
                end else if (c.x <= s) begin
                    n.x = 0; n.ml = 1; n.st = 2; n.lost_r = 0;
                    n.sr = (c.sr < 15) ? c.sr + 1 : 15;
                end else begin
                    n.x = c.x - s;
                end
            end
        end else begin
            n.x = CX; n.y = CY; n.dx = c.lost_r; n.sdy = 1 - c.sdy; n.dy = 1 - c.sdy; n.st = 0;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m <= model_next(m, reset, tick, int'(speed), int'(paddle_l_y), int'(paddle_r_y));
    end

    task automatic check(string nm, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Literal expectation: pins both the DUT and the model.
    task automatic lit(string nm, int dut_v, int mdl_v, int exp);
        check({nm, "_dut"}, dut_v, exp);
        check({nm, "_model"}, mdl_v, exp);
    endtask

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("state", int'(state), m.st);
            check("ball_x", int'(ball_x), m.x);
            check("ball_y", int'(ball_y), m.y);
            check("dir_x", int'(dir_x), m.dx);
            check("dir_y", int'(dir_y), m.dy);
            check("hit_l", int'(hit_l), m.hl);
            check("hit_r", int'(hit_r), m.hr);
            check("miss_l", int'(miss_l), m.ml);
            check("miss_r", int'(miss_r), m.mr);
            check("score_l", int'(score_l), m.sl);
            check("score_r", int'(score_r), m.sr);
        end
    end

    task automatic do_tick();
        @(negedge clk);
        if (follow) begin
            paddle_l_y = 11'(m.y);
            paddle_r_y = 11'(m.y);
        end
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic check_reset_vals(string nm);
        lit({nm, "_state"}, int'(state), m.st, 0);
        lit({nm, "_x"}, int'(ball_x), m.x, 78);
        lit({nm, "_y"}, int'(ball_y), m.y, 58);
        lit({nm, "_dx"}, int'(dir_x), m.dx, 1);
        lit({nm, "_dy"}, int'(dir_y), m.dy, 1);
        lit({nm, "_sl"}, int'(score_l), m.sl, 0);
        lit({nm, "_sr"}, int'(score_r), m.sr, 0);
        lit({nm, "_pulses"}, int'({hit_l, hit_r, miss_l, miss_r}), m.hl + m.hr + m.ml + m.mr, 0);
    endtask

    task automatic run_until_hits(int want);
        int hits;
        int n;
        hits = 0;
        n = 0;
        while (hits < want && n < 600) begin
            do_tick();
            hits += m.hl + m.hr;
            n++;
        end
        if (hits < want) begin
            n_total++;
            $display("FAIL hit_timeout: got %0d hits, expected %0d", hits, want);
        end
    endtask

    initial begin
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check_reset_vals("rst");
        reset = 1'b1;

        // Serve: 59 ticks hold, the 60th enters play without moving.
        repeat (59) do_tick();
        lit("serve59_state", int'(state), m.st, 0);
        lit("serve59_x", int'(ball_x), m.x, 78);
        do_tick();
        lit("serve60_state", int'(state), m.st, 1);
        lit("serve60_y", int'(ball_y), m.y, 58);
        do_tick();
        lit("play1_x", int'(ball_x), m.x, 80);
        lit("play1_y", int'(ball_y), m.y, 60);

        // Bottom bounce at play tick 29, right paddle (y=100) hit at play tick 35.
        repeat (34) do_tick();
        lit("hitr_x", int'(ball_x), m.x, 148);
        lit("hitr_y", int'(ball_y), m.y, 104);
        lit("hitr_dx", int'(dir_x), m.dx, 0);
        lit("hitr_dy", int'(dir_y), m.dy, 0);
        lit("hitr_pulse", int'(hit_r), m.hr, 1);
        @(negedge clk);
        lit("hitr_clear", int'(hit_r), m.hr, 0);

        // Top bounce after 52 ticks, left paddle missed, ball out after 74 ticks.
        repeat (74) do_tick();
        lit("missl_x", int'(ball_x), m.x, 0);
        lit("missl_y", int'(ball_y), m.y, 44);
        lit("missl_pulse", int'(miss_l), m.ml, 1);
        lit("missl_score", int'(score_r), m.sr, 1);
        lit("missl_state", int'(state), m.st, 2);
        do_tick();
        lit("point_x", int'(ball_x), m.x, 78);
        lit("point_dx", int'(dir_x), m.dx, 0);
        lit("point_dy", int'(dir_y), m.dy, 0);
        lit("point_state", int'(state), m.st, 0);

        // Top-wall clamp from y=1 with step 3, then 1 px with speed 0.
        speed = 5'd3;
        repeat (60) do_tick();
        repeat (20) do_tick();
        lit("clamp_x", int'(ball_x), m.x, 18);
        lit("clamp_y", int'(ball_y), m.y, 0);
        lit("clamp_dy", int'(dir_y), m.dy, 1);
        speed = 5'd0;
        do_tick();
        lit("slow_x", int'(ball_x), m.x, 17);
        lit("slow_y", int'(ball_y), m.y, 1);

        // Sixteen more left misses with paddles out of reach.
        speed = 5'd31;
        paddle_l_y = 11'd1000;
        paddle_r_y = 11'd1000;
        for (int r = 0; r < 16; r++) begin
            int n;
            n = 0;
            while (m.st != 2 && n < 300) begin
                do_tick();
                n++;
            end
            if (m.st != 2) begin
                n_total++;
                $display("FAIL rally_timeout: rally %0d no point after %0d ticks", r, n);
            end
            do_tick();
        end
        lit("sat_score_r", int'(score_r), m.sr, 15);
        lit("sat_score_l", int'(score_l), m.sl, 0);

        // Reset mid-rally, with tick asserted at the same time.
        repeat (61) do_tick();
        @(negedge clk);
        reset = 1'b0;
        tick = 1'b1;
        @(negedge clk);
        check_reset_vals("midrst");
        tick = 1'b0;
        reset = 1'b1;

        if (SPEEDUP) begin
            // Three hits from step 2 give step 5; third hit is on the right.
            speed = 5'd2;
            follow = 1'b1;
            repeat (60) do_tick();
            run_until_hits(3);
            lit("spd_hit3_x", int'(ball_x), m.x, 148);
            check("spd_step5_model", m.step, 5);
            do_tick();
            lit("spd_step5_move", int'(ball_x), m.x, 143);

            // Step stays at 31 after a hit.
            @(negedge clk);
            speed = 5'd31;
            reset = 1'b0;
            @(negedge clk);
            reset = 1'b1;
            repeat (60) do_tick();
            run_until_hits(1);
            check("spd_sat_model", m.step, 31);
            do_tick();
            lit("spd_sat_move", int'(ball_x), m.x, 117);
            follow = 1'b0;
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

endmodule
